// File: rtl/neptuno_joy_scanner.sv
// rtl/neptuno_joy_scanner.sv - DB9 joystick shift-chain scanner with Megadrive select sequencing
// Optional JOY_MD6_EN: 8-phase frame with 6-button detection and x/y/z/mode decode.
module neptuno_joy_scanner #(
   parameter int CLK_DIV      = 32,
   parameter int SCAN_BITS    = 16,
   parameter int SETTLE_TICKS = 4
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   output logic        JOY_CLK,
   output logic        JOY_LOAD,
   input  logic        JOY_DATA,
   output logic        JOY_SEL,
   output logic [11:0] joy1,
   output logic [11:0] joy2,
   output logic        frame_strobe
);

`ifdef JOY_MD6_EN
   localparam logic [2:0] LAST_PHASE = 3'd7;
`else
   localparam logic [2:0] LAST_PHASE = 3'd1;
`endif

   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_MAX = (SCAN_BITS > SETTLE_TICKS) ? SCAN_BITS : SETTLE_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [DIV_W-1:0] TICK_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(SCAN_BITS - 1);
   localparam logic [CNT_W-1:0] P1_END      = CNT_W'(6);
   localparam logic [CNT_W-1:0] P2_START    = CNT_W'(8);
   localparam logic [CNT_W-1:0] P2_END      = CNT_W'(14);

   typedef enum logic [2:0] {
      SETTLE,
      LOAD,
      SHIFT_LO,
      SHIFT_HI,
      NEXT
   } state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] tick_cnt;
   logic             tick;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       phase, phase_nxt;

   logic [5:0]  pins1, pins2;
   logic [11:0] stage1, stage2, stage1_nxt, stage2_nxt;
   logic        six1, six2, six1_nxt, six2_nxt;
   logic        sample;

   // Folds one phase's pin snapshot of a port into its staging vector.
   function automatic logic [12:0] decode_port(input logic [2:0]  ph,
                                               input logic [5:0]  pins,
                                               input logic [11:0] st,
                                               input logic        six);
      logic [11:0] s;
      logic        sx;
      logic        md;
      s  = st;
      sx = six;
      md = pins[2] & pins[3];
      case (ph)
         3'd0: s[5:0] = {pins[5], pins[4], pins[0], pins[1], pins[2], pins[3]};
         3'd1: s[7:6] = md ? {pins[5], pins[4]} : 2'b00;
`ifdef JOY_MD6_EN
         3'd5: sx = &pins[3:0];
         3'd6: s[11:8] = sx ? {pins[3], pins[0], pins[1], pins[2]} : 4'h0;
`endif
         default: ;
      endcase
      return {sx, s};
   endfunction

   assign tick   = (tick_cnt == TICK_LAST);
   assign sample = tick && (state == SHIFT_LO);

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
         state    <= SETTLE;
         cnt      <= '0;
         phase    <= 3'd0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         phase    <= phase_nxt;
      end
   end

   // NEXT lasts a single clk; the free-running tick keeps each phase at whole ticks.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      phase_nxt = phase;
      JOY_CLK   = 1'b0;
      JOY_LOAD  = 1'b1;
      JOY_SEL   = ~phase[0];
      case (state)
         SETTLE: begin
            if (tick) begin
               if (cnt == SETTLE_LAST) begin
                  state_nxt = LOAD;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         LOAD: begin
            JOY_LOAD = 1'b0;
            if (tick) state_nxt = SHIFT_LO;
         end
         SHIFT_LO: begin
            if (tick) state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            JOY_CLK = 1'b1;
            if (tick) begin
               if (cnt == SHIFT_LAST) begin
                  state_nxt = NEXT;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = SHIFT_LO;
                  cnt_nxt   = cnt + 1'b1;
               end
            end
         end
         NEXT: begin
            state_nxt = SETTLE;
            phase_nxt = (phase == LAST_PHASE) ? 3'd0 : phase + 3'd1;
         end
         default: state_nxt = SETTLE;
      endcase
   end

   always_comb begin
      {six1_nxt, stage1_nxt} = decode_port(phase, pins1, stage1, six1);
      {six2_nxt, stage2_nxt} = decode_port(phase, pins2, stage2, six2);
   end

   // Only frame bits [5:0] and [13:8] carry decoded pins; the rest are clocked past.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         pins1        <= '0;
         pins2        <= '0;
         stage1       <= '0;
         stage2       <= '0;
         six1         <= 1'b0;
         six2         <= 1'b0;
         joy1         <= '0;
         joy2         <= '0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= 1'b0;
         if (sample) begin
            if (cnt < P1_END)
               pins1[cnt[2:0]] <= ~JOY_DATA;
            else if (cnt >= P2_START && cnt < P2_END)
               pins2[cnt[2:0]] <= ~JOY_DATA;
         end
         if (state == NEXT) begin
            stage1 <= stage1_nxt;
            stage2 <= stage2_nxt;
            six1   <= six1_nxt;
            six2   <= six2_nxt;
            if (phase == LAST_PHASE) begin
               joy1         <= stage1_nxt;
               joy2         <= stage2_nxt;
               frame_strobe <= 1'b1;
            end
         end
      end
   end

endmodule
